// File: rtl/sb_dec2fp_conv.sv
// Keypad decimal entry to IEEE-754 single-precision converter.
// Builds integer and BCD fraction, converts the fraction to binary, normalises and packs.
module sb_dec2fp_conv #(
    parameter int unsigned INT_BITS    = 32,
    parameter int unsigned FRAC_DIGITS = 8,
    parameter int unsigned FRAC_BITS   = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        finish,
    output logic [31:0] result,
    output logic        done,
    output logic        busy,
    output logic        ovf
);

    localparam int unsigned W    = INT_BITS + FRAC_BITS;
    localparam int unsigned BcdW = FRAC_DIGITS * 4;
    localparam int unsigned CntW = $clog2(FRAC_BITS);
    localparam int unsigned ShW  = $clog2(W + 1);
    localparam int unsigned FdW  = $clog2(FRAC_DIGITS + 1);

    localparam logic [3:0] KeyMinus = 4'hE;
    localparam logic [3:0] KeyPoint = 4'hF;

    typedef enum logic [2:0] {
        StEntryInt,
        StEntryFrac,
        StConv,
        StNorm,
        StPack,
        StDone
    } state_e;

    state_e                st_q, st_d;
    logic [INT_BITS-1:0]   int_acc_q, int_acc_d;
    logic [BcdW-1:0]       bcd_q, bcd_d;
    logic [FdW-1:0]        frac_cnt_q, frac_cnt_d;
    logic [FRAC_BITS-1:0]  frac_bits_q, frac_bits_d;
    logic                  sign_q, sign_d;
    logic                  ovf_q, ovf_d;
    logic [ShW-1:0]        sh_q, sh_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [31:0]           result_q, result_d;

    logic [W-1:0]          v;
    logic [BcdW-1:0]       bcd_dbl;
    logic                  dbl_carry;
    logic [INT_BITS+3:0]   acc_ext;
    logic [31:0]           exp_full;
    logic                  wipe;
    state_e                eff_st;

    assign v        = {int_acc_q, frac_bits_q};
    assign exp_full = 32'(127 + INT_BITS - 1) - 32'(sh_q);

    // One decimal-adjusted doubling of the BCD fraction; carry out of the MSD is the next bit.
    always_comb begin : bcd_double
        logic       c;
        logic [4:0] s;
        c       = 1'b0;
        s       = '0;
        bcd_dbl = '0;
        for (int i = 0; i < int'(FRAC_DIGITS); i++) begin
            if (bcd_q[i*4 +: 4] > 4'd4) begin
                s = {bcd_q[i*4 +: 4], 1'b0} + 5'd6 + {4'b0, c};
                c = 1'b1;
            end else begin
                s = {bcd_q[i*4 +: 4], 1'b0} + {4'b0, c};
                c = 1'b0;
            end
            bcd_dbl[i*4 +: 4] = s[3:0];
        end
        dbl_carry = c;
    end

    always_comb begin
        st_d        = st_q;
        int_acc_d   = int_acc_q;
        bcd_d       = bcd_q;
        frac_cnt_d  = frac_cnt_q;
        frac_bits_d = frac_bits_q;
        sign_d      = sign_q;
        ovf_d       = ovf_q;
        sh_d        = sh_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        acc_ext     = '0;

        // A key in DONE restarts from a clean slate and is then handled as a first entry.
        wipe   = clear | ((st_q == StDone) & key_valid);
        eff_st = wipe ? StEntryInt : st_q;

        if (wipe) begin
            st_d        = StEntryInt;
            int_acc_d   = '0;
            bcd_d       = '0;
            frac_cnt_d  = '0;
            frac_bits_d = '0;
            sign_d      = 1'b0;
            ovf_d       = 1'b0;
            sh_d        = '0;
            cnt_d       = '0;
            result_d    = '0;
        end

        if (!clear) begin
            case (eff_st)
                StEntryInt, StEntryFrac: begin
                    if (finish && !wipe) begin
                        st_d  = StConv;
                        cnt_d = '0;
                    end else if (key_valid) begin
                        if (key_code <= 4'd9) begin
                            if (eff_st == StEntryInt) begin
                                if (!ovf_d) begin
                                    acc_ext = ({4'b0, int_acc_d} << 3) + ({4'b0, int_acc_d} << 1)
                                              + {{INT_BITS{1'b0}}, key_code};
                                    if (acc_ext[INT_BITS +: 4] != 4'd0) begin
                                        ovf_d = 1'b1;
                                    end else begin
                                        int_acc_d = acc_ext[INT_BITS-1:0];
                                    end
                                end
                            end else if (frac_cnt_d < FdW'(FRAC_DIGITS)) begin
                                for (int i = 0; i < int'(FRAC_DIGITS); i++) begin
                                    if (FdW'(i) == frac_cnt_d) begin
                                        bcd_d[(int'(FRAC_DIGITS) - 1 - i)*4 +: 4] = key_code;
                                    end
                                end
                                frac_cnt_d = frac_cnt_d + 1'b1;
                            end
                        end else if (key_code == KeyMinus) begin
                            sign_d = ~sign_d;
                        end else if (key_code == KeyPoint) begin
                            st_d = StEntryFrac;
                        end
                    end
                end
                StConv: begin
                    bcd_d       = bcd_dbl;
                    frac_bits_d = {frac_bits_q[FRAC_BITS-2:0], dbl_carry};
                    if (cnt_q == CntW'(FRAC_BITS - 1)) begin
                        st_d = ovf_q ? StPack : StNorm;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StNorm: begin
                    if ((v == '0) || v[W-1]) begin
                        st_d = StPack;
                    end else begin
                        {int_acc_d, frac_bits_d} = v << 1;
                        sh_d = sh_q + 1'b1;
                    end
                end
                StPack: begin
                    if (ovf_q) begin
                        result_d = {sign_q, 8'hFF, 23'h0};
                    end else if (v == '0) begin
                        result_d = 32'h0;
                    end else begin
                        result_d = {sign_q, exp_full[7:0], v[W-2 -: 23]};
                    end
                    st_d = StDone;
                end
                StDone: begin
                end
                default: st_d = StEntryInt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= StEntryInt;
            int_acc_q   <= '0;
            bcd_q       <= '0;
            frac_cnt_q  <= '0;
            frac_bits_q <= '0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            sh_q        <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
        end else begin
            st_q        <= st_d;
            int_acc_q   <= int_acc_d;
            bcd_q       <= bcd_d;
            frac_cnt_q  <= frac_cnt_d;
            frac_bits_q <= frac_bits_d;
            sign_q      <= sign_d;
            ovf_q       <= ovf_d;
            sh_q        <= sh_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
        end
    end

    assign result = result_q;
    assign done   = (st_q == StDone);
    assign busy   = (st_q == StConv) || (st_q == StNorm) || (st_q == StPack);
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_sb_dec2fp_conv.sv
// Directed bench for sb_dec2fp_conv: expected results queued at entry, compared at done.
module tb_sb_dec2fp_conv;

    localparam int FracBits = 24;
    localparam int IntBits  = 32;
    localparam int LatMax   = FracBits + IntBits + FracBits + 3;
    localparam int LatZero  = FracBits + 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        finish = 1'b0;
    logic [31:0] result;
    logic        done;
    logic        busy;
    logic        ovf;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    sb_dec2fp_conv #(
        .INT_BITS   (IntBits),
        .FRAC_DIGITS(8),
        .FRAC_BITS  (FracBits)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .key_valid(key_valid),
        .key_code (key_code),
        .finish   (finish),
        .result   (result),
        .done     (done),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
    endtask

    // seq holds n key codes, first key in the most significant used nibble.
    task automatic run_num(input string tag, input logic [63:0] seq, input int n,
                           input logic [31:0] expv, input logic exp_ovf, input int lim,
                           input bit key_on_finish);
        int          cyc;
        logic [31:0] want;
        exp_q.push_back(expv);
        for (int i = 0; i < n; i++) begin
            press(seq[4*(n-1-i) +: 4]);
        end
        finish = 1'b1;
        if (key_on_finish) begin
            key_valid = 1'b1;
            key_code  = 4'd7;
        end
        tick();
        finish    = 1'b0;
        key_valid = 1'b0;
        check({tag, "_busy_start"}, {31'b0, busy}, 32'd1);
        cyc = 0;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        n_checks++;
        assert (done === 1'b1 && cyc <= lim) else begin
            n_fail++;
            $error("FAIL %s_latency: done=%b after %0d cycles, required done=1 within %0d",
                   tag, done, cyc, lim);
        end
        want = exp_q.pop_front();
        check({tag, "_result"}, result, want);
        check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, exp_ovf});
        check({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
        tick();
        check({tag, "_hold"}, result, want);
    endtask

    initial begin
        // Bus activity during reset must leave no trace.
        key_valid = 1'b1;
        key_code  = 4'd9;
        finish    = 1'b1;
        #1;
        check("rst_result", result, 32'h0);
        check("rst_flags", {29'b0, done, busy, ovf}, 32'd0);
        repeat (3) tick();
        key_valid = 1'b0;
        finish    = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_flags", {29'b0, done, busy, ovf}, 32'd0);

        run_num("p12_5",   64'h12F5, 4, 32'h41480000, 1'b0, LatMax, 1'b0);
        run_num("m0_75",   64'hE0F75, 5, 32'hBF400000, 1'b0, LatMax, 1'b0);
        run_num("p0_1",    64'h0F1, 3, 32'h3DCCCCC8, 1'b0, LatMax, 1'b0);
        run_num("m_zero",  64'hE0, 2, 32'h00000000, 1'b0, LatZero, 1'b0);
        run_num("ovf",     64'h99999999999, 11, 32'h7F800000, 1'b1, LatMax, 1'b0);
        // Double minus, ignored A key, repeated point: 2.5.
        run_num("p2_5",    64'hEAE2FF5, 7, 32'h40200000, 1'b0, LatMax, 1'b0);
        // Key coincident with finish is dropped: 1.0, not 17.
        run_num("drop_key", 64'h1, 1, 32'h3F800000, 1'b0, LatMax, 1'b1);

        // Abort five cycles into conversion.
        press(4'd1);
        press(4'd2);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        repeat (4) tick();
        check("clr_busy_before", {31'b0, busy}, 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_flags", {29'b0, done, busy, ovf}, 32'd0);
        check("clr_result", result, 32'h0);
        run_num("after_clr", 64'h3, 1, 32'h40400000, 1'b0, LatMax, 1'b0);

        // Asynchronous reset takes effect without a clock edge.
        rst_n = 1'b0;
        #1;
        check("async_rst_result", result, 32'h0);
        check("async_rst_flags", {29'b0, done, busy, ovf}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
